// File: rtl/cnn_seq_pkg.sv
// ----------------------------------------------------------------------------
// cnn_seq_pkg
// Shared definitions for the CNN layer sequencer: sequencer state encoding,
// the index of each layer in the pipeline and the default layer count.
// No ports (package).
// ----------------------------------------------------------------------------
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_RUN       = 2'd2,
        ST_ABORT_CLR = 2'd3
    } seq_state_e;

    localparam int NUM_STAGES_DEF = 5;
    localparam int STAGE_IDX_W    = 3;

    localparam logic [STAGE_IDX_W-1:0] STG_C1 = 3'd0;
    localparam logic [STAGE_IDX_W-1:0] STG_P1 = 3'd1;
    localparam logic [STAGE_IDX_W-1:0] STG_C2 = 3'd2;
    localparam logic [STAGE_IDX_W-1:0] STG_P2 = 3'd3;
    localparam logic [STAGE_IDX_W-1:0] STG_FC = 3'd4;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// cnn_layer_sequencer_if
// Bundles the host handshake (start/abort/busy/done/error/cur_stage) and the
// layer-counter control (stage_done/stage_en/stage_clr) of the sequencer.
//   master : host + layer counters side (drives start, abort, stage_done)
//   slave  : sequencer side (drives stage_en, stage_clr, busy, done, error,
//            cur_stage)
// ----------------------------------------------------------------------------
interface cnn_layer_sequencer_if #(
    parameter int NUM_STAGES = cnn_seq_pkg::NUM_STAGES_DEF
);
    logic                                start;
    logic                                abort;
    logic [NUM_STAGES-1:0]               stage_done;
    logic [NUM_STAGES-1:0]               stage_en;
    logic [NUM_STAGES-1:0]               stage_clr;
    logic                                busy;
    logic                                done;
    logic                                error;
    logic [cnn_seq_pkg::STAGE_IDX_W-1:0] cur_stage;

    modport master (
        output start, abort, stage_done,
        input  stage_en, stage_clr, busy, done, error, cur_stage
    );

    modport slave (
        input  start, abort, stage_done,
        output stage_en, stage_clr, busy, done, error, cur_stage
    );
endinterface

// File: rtl/seq_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog
// Clearable, saturating up-counter. expired is high while the count sits at
// LIMIT-1; the count never wraps.
// Ports:
//   clk     : clock
//   reset   : asynchronous active-high reset (count -> 0)
//   clr     : synchronous clear (count -> 0), dominates en
//   en      : count enable
//   expired : count == LIMIT-1
// ----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 4000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);
endmodule

// File: rtl/cnn_layer_sequencer.sv
// ----------------------------------------------------------------------------
// cnn_layer_sequencer
// Runs the layer counters (conv1, pool1, conv2, pool2, dense) strictly in
// order: each stage gets a CLR_CYCLES clear pulse, then its enable is held
// until its done flag is seen. Provides start/busy/done/error to the host,
// a per-stage watchdog and an abort path that clears every layer counter.
// All outputs are registered.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : cnn_layer_sequencer_if.slave (start, abort, stage_done in;
//           stage_en, stage_clr, busy, done, error, cur_stage out)
// ----------------------------------------------------------------------------
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT    = 4000
) (
    input  logic                  clk,
    input  logic                  reset,
    cnn_layer_sequencer_if.slave  bus
);
    localparam logic [STAGE_IDX_W-1:0] LAST_IDX  = STAGE_IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0]  STAGE_ONE = NUM_STAGES'(1);

    seq_state_e              state_q, state_d;
    logic [STAGE_IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_en_q, stage_en_d;
    logic [NUM_STAGES-1:0]   stage_clr_q, stage_clr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic start_acc;   // start accepted this cycle
    logic run_ok;      // last stage reported done
    logic run_tmo;     // active stage hit the watchdog limit
    logic state_chg;
    logic hold_exp;
    logic wd_exp;
    logic cur_done;

    assign cur_done  = bus.stage_done[idx_q];
    // Both counters restart on every state transition, so each state's
    // first cycle sees a count of zero.
    assign state_chg = (state_d != state_q);

    seq_watchdog #(
        .WIDTH (3),
        .LIMIT (CLR_CYCLES)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_chg),
        .en      (1'b1),
        .expired (hold_exp)
    );

    seq_watchdog #(
        .WIDTH (TIMEOUT_W),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_chg),
        .en      (state_q == ST_RUN),
        .expired (wd_exp)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            stage_en_q  <= '0;
            stage_clr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_en_q  <= stage_en_d;
            stage_clr_q <= stage_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next state. Abort beats start in IDLE and beats done in RUN;
    // done beats watchdog expiry.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_acc = 1'b0;
        run_ok    = 1'b0;
        run_tmo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d   = ST_CLEAR;
                    idx_d     = '0;
                    start_acc = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (bus.abort) begin
                    state_d = ST_ABORT_CLR;
                end else if (hold_exp) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_ABORT_CLR;
                end else if (cur_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        run_ok  = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (wd_exp) begin
                    // idx is kept so cur_stage reports the failing stage
                    state_d = ST_IDLE;
                    run_tmo = 1'b1;
                end
            end
            ST_ABORT_CLR: begin
                if (hold_exp) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step
    // with the state itself.
    always_comb begin
        stage_en_d  = '0;
        stage_clr_d = '0;
        case (state_d)
            ST_CLEAR:     stage_clr_d = STAGE_ONE << idx_d;
            ST_RUN:       stage_en_d  = STAGE_ONE << idx_d;
            ST_ABORT_CLR: stage_clr_d = '1;
            default:      ;
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = done_q;
        error_d = error_q;
        if (start_acc) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end
        if (run_ok) begin
            done_d = 1'b1;
        end
        if (run_tmo) begin
            error_d = 1'b1;
        end
    end

    assign bus.stage_en  = stage_en_q;
    assign bus.stage_clr = stage_clr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.cur_stage = idx_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cnn_layer_sequencer
// Directed + randomized bench for cnn_layer_sequencer (CLR_CYCLES=2,
// TIMEOUT=20). For each run a cycle-by-cycle timeline of expected outputs is
// built from per-stage done latencies, then the DUT is stepped and compared.
// ----------------------------------------------------------------------------
module tb_cnn_layer_sequencer;
    import cnn_seq_pkg::*;

    localparam int NS  = 5;
    localparam int CLR = 2;
    localparam int TO  = 20;
    localparam int MAXC = 256;

    localparam int PH_IDLE = 0;
    localparam int PH_CLR  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_ABT  = 3;

    logic clk = 1'b0;
    logic reset;

    cnn_layer_sequencer_if #(.NUM_STAGES(NS)) bus ();

    cnn_layer_sequencer #(
        .NUM_STAGES (NS),
        .CLR_CYCLES (CLR),
        .TIMEOUT_W  (16),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    int checks = 0;
    int errors = 0;

    // Per-run stimulus description
    int cj [NS];        // enabled cycles before done (index of the done cycle); >=TO means never
    int abort_at   = -1;
    int restart_at = -1;
    int reset_at   = -1;

    // Expected timeline, cycle k = interval following the k-th clock edge of the run
    int         m_phase [MAXC];
    logic [4:0] m_en    [MAXC];
    logic [4:0] m_clr   [MAXC];
    logic       m_busy  [MAXC];
    logic       m_done  [MAXC];
    logic       m_err   [MAXC];
    int         m_cur   [MAXC];
    int         m_stg   [MAXC];
    logic       m_drv   [MAXC];
    int         n_cyc;

    logic exp_done_s = 1'b0;
    logic exp_err_s  = 1'b0;
    int   exp_cur_s  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] onehot(input int i);
        logic [4:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int run_len(input int i);
        return (cj[i] < TO) ? cj[i] + 1 : TO;
    endfunction

    function automatic int run_start(input int i);
        int b;
        b = 0;
        for (int s = 0; s < i; s++) b += CLR + run_len(s);
        return b + CLR;
    endfunction

    task automatic put(input int k, input int ph, input logic [4:0] en, input logic [4:0] cl,
                       input logic bsy, input logic dn, input logic er, input int cur,
                       input int stg, input logic drv);
        m_phase[k] = ph; m_en[k] = en; m_clr[k] = cl; m_busy[k] = bsy;
        m_done[k] = dn; m_err[k] = er; m_cur[k] = cur; m_stg[k] = stg; m_drv[k] = drv;
    endtask

    task automatic build_model();
        int k;
        int fail;
        k    = 0;
        fail = -1;
        for (int i = 0; i < NS; i++) begin
            for (int c = 0; c < CLR; c++) begin
                put(k, PH_CLR, 5'b0, onehot(i), 1'b1, 1'b0, 1'b0, i, i, 1'b0);
                k++;
            end
            for (int m = 0; m < run_len(i); m++) begin
                put(k, PH_RUN, onehot(i), 5'b0, 1'b1, 1'b0, 1'b0, i, i, (m == cj[i]));
                k++;
            end
            if (cj[i] >= TO) begin
                fail = i;
                break;
            end
        end
        for (int t = 0; t < 3; t++)
            put(k + t, PH_IDLE, 5'b0, 5'b0, 1'b0, (fail < 0), (fail >= 0),
                (fail < 0) ? 0 : fail, 0, 1'b0);
        n_cyc = k + 3;
        if (abort_at >= 0) begin
            for (int t = 1; t <= 2; t++)
                put(abort_at + t, PH_ABT, 5'b0, 5'h1f, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
            for (int t = 3; t <= 5; t++)
                put(abort_at + t, PH_IDLE, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            n_cyc = abort_at + 6;
        end
    endtask

    task automatic drive_inputs(input int k);
        logic [4:0] d;
        int s;
        d = 5'($urandom);
        s = m_stg[k];
        case (m_phase[k])
            PH_RUN: begin
                if (s == 1) d = 5'h1f;   // every other stage (incl. dense) flags done spuriously
                d[s] = m_drv[k];
            end
            PH_CLR: if (cj[s] == 0) d[s] = 1'b1;   // done already up before the stage runs
            default: ;
        endcase
        bus.stage_done = d;
        bus.start      = (k == restart_at);
        bus.abort      = (k == abort_at);
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, ":en"},   32'(bus.stage_en),  32'(0));
        chk({name, ":clr"},  32'(bus.stage_clr), 32'(0));
        chk({name, ":busy"}, 32'(bus.busy),      32'(0));
        chk({name, ":done"}, 32'(bus.done),      32'(0));
        chk({name, ":err"},  32'(bus.error),     32'(0));
        chk({name, ":cur"},  32'(bus.cur_stage), 32'(0));
    endtask

    task automatic run_case(input string name);
        bit stopped;
        stopped = 1'b0;
        build_model();
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.stage_done = 5'($urandom);
        for (int k = 0; k < n_cyc; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s:en@%0d", name, k),   32'(bus.stage_en),  32'(m_en[k]));
            chk($sformatf("%s:clr@%0d", name, k),  32'(bus.stage_clr), 32'(m_clr[k]));
            chk($sformatf("%s:busy@%0d", name, k), 32'(bus.busy),      32'(m_busy[k]));
            chk($sformatf("%s:done@%0d", name, k), 32'(bus.done),      32'(m_done[k]));
            chk($sformatf("%s:err@%0d", name, k),  32'(bus.error),     32'(m_err[k]));
            if (m_cur[k] >= 0)
                chk($sformatf("%s:cur@%0d", name, k), 32'(bus.cur_stage), 32'(m_cur[k]));
            if (k == reset_at) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                #1 reset = 1'b1;
                #1;
                chk_idle_zero($sformatf("%s:async_rst@%0d", name, k));
                @(negedge clk);
                reset     = 1'b0;
                stopped   = 1'b1;
                break;
            end
            drive_inputs(k);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (stopped) begin
            exp_done_s = 1'b0;
            exp_err_s  = 1'b0;
            exp_cur_s  = 0;
        end else begin
            exp_done_s = m_done[n_cyc-1];
            exp_err_s  = m_err[n_cyc-1];
            exp_cur_s  = m_cur[n_cyc-1];
        end
        abort_at   = -1;
        restart_at = -1;
        reset_at   = -1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.stage_done = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal run: every stage done on its 5th enabled cycle
        cj = '{4, 4, 4, 4, 4};
        run_case("nominal");

        // pool2 never finishes: watchdog expiry
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        cj[STG_P2] = TO + 5;
        run_case("hang_p2");

        // Restart clears error; conv2 done on the very cycle the watchdog expires
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        cj[STG_C2] = TO - 1;
        run_case("restart");

        // start together with abort in IDLE, then a lone abort in IDLE
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.stage_done = 5'($urandom);
        @(posedge clk);
        #1;
        chk("idle_start_abort:busy", 32'(bus.busy),      32'(0));
        chk("idle_start_abort:clr",  32'(bus.stage_clr), 32'(0));
        chk("idle_start_abort:en",   32'(bus.stage_en),  32'(0));
        chk("idle_start_abort:done", 32'(bus.done),      32'(exp_done_s));
        chk("idle_start_abort:err",  32'(bus.error),     32'(exp_err_s));
        chk("idle_start_abort:cur",  32'(bus.cur_stage), 32'(exp_cur_s));
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_abort:busy", 32'(bus.busy),      32'(0));
        chk("idle_abort:clr",  32'(bus.stage_clr), 32'(0));
        bus.abort = 1'b0;

        // Abort during conv2 RUN
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        cj[STG_C2] = $urandom_range(2, 8);
        abort_at = run_start(STG_C2) + $urandom_range(0, cj[STG_C2] - 1);
        run_case("abort_run_c2");

        // Abort during pool1 CLEAR
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        abort_at = run_start(STG_P1) - CLR + $urandom_range(0, CLR - 1);
        run_case("abort_clr_p1");

        // conv1 done pre-asserted, start re-pulsed and spurious done during pool1
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        cj[STG_C1] = 0;
        cj[STG_P1] = 6;
        restart_at = run_start(STG_P1) + 1;
        run_case("early_done");

        // Randomized runs, sometimes aborted
        for (int r = 0; r < 4; r++) begin
            int s;
            for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, NS - 1);
                abort_at = run_start(s) - CLR + $urandom_range(0, CLR + cj[s] - 1);
            end
            run_case($sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of conv2 CLEAR, then a clean run
        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        reset_at = run_start(STG_C2) - CLR + $urandom_range(0, CLR - 1);
        run_case("reset_mid_clr");

        for (int i = 0; i < NS; i++) cj[i] = $urandom_range(0, 6);
        cj[STG_FC] = $urandom_range(0, 3);
        run_case("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
